// File: rtl/tx_packet_ctrl_if.sv
// Handshake/data bundle between the USB TX packet controller, its FIFO/CRC
// sources and the parallel-to-serial stage.
interface tx_packet_ctrl_if #(
  parameter int MAX_BYTES = 64
);
  localparam int SW = $clog2(MAX_BYTES + 1);

  logic [2:0]    tx_packet;
  logic [7:0]    tx_packet_data;
  logic [SW-1:0] tx_packet_data_size;
  logic          stuffing;
  logic [15:0]   calculated_crc;

  logic          get_tx_packet_data;
  logic          crc_clear;
  logic          crc_shift;
  logic          pts_load;
  logic          pts_shift;
  logic          eop;
  logic          tx_busy;
  logic          tx_done;
  logic [7:0]    data_out;

  modport master (
    output tx_packet, tx_packet_data, tx_packet_data_size, stuffing, calculated_crc,
    input  get_tx_packet_data, crc_clear, crc_shift, pts_load, pts_shift,
           eop, tx_busy, tx_done, data_out
  );

  modport slave (
    input  tx_packet, tx_packet_data, tx_packet_data_size, stuffing, calculated_crc,
    output get_tx_packet_data, crc_clear, crc_shift, pts_load, pts_shift,
           eop, tx_busy, tx_done, data_out
  );
endinterface

// File: rtl/tx_packet_ctrl.sv
// USB TX packet sequencer: SYNC, PID, payload, CRC16 and EOP framing with
// bit timing that freezes while the encoder inserts a stuff bit.
module tx_packet_ctrl #(
  parameter int MAX_BYTES    = 64,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  tx_packet_ctrl_if.slave   bus
);
  localparam int SW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int EW = $clog2(2 * CLKS_PER_BIT);
  localparam logic [SW-1:0] MAX_SZ   = SW'(MAX_BYTES);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [EW-1:0] EOP_LAST = EW'(2 * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [2:0]    pkt_type;
  logic [SW-1:0] pkt_size;
  logic [SW-1:0] byte_cnt;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_cnt;
  logic [EW-1:0] eop_cnt;
  logic          sync_load;

  logic          req_valid, shifting, tick, byte_end;
  logic          pop, clr, cshift, load, shift;
  logic [7:0]    dout, pid_byte;

  assign req_valid = (bus.tx_packet != 3'd0) && (bus.tx_packet <= 3'd5);
  assign shifting  = (state == SYNC) || (state == PID) || (state == DATA) ||
                     (state == CRC_LO) || (state == CRC_HI);
  assign tick      = shifting && !bus.stuffing && (bit_timer == T_LAST);
  assign byte_end  = tick && (bit_cnt == 3'd7);

  always_comb begin
    case (pkt_type)
      3'd1:    pid_byte = 8'hC3;
      3'd2:    pid_byte = 8'h4B;
      3'd3:    pid_byte = 8'hD2;
      3'd4:    pid_byte = 8'h5A;
      3'd5:    pid_byte = 8'h1E;
      default: pid_byte = 8'h00;
    endcase
  end

  // A byte-end that loads the next byte replaces the 8th shift; the final
  // byte before EOP keeps its shift so the last bit leaves the PTS.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    clr     = 1'b0;
    cshift  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    dout    = '0;
    case (state)
      IDLE: if (req_valid) state_n = SYNC;
      SYNC: begin
        shift = tick;
        if (sync_load && !bus.stuffing) begin
          load = 1'b1;
          dout = 8'h80;
        end
        if (byte_end) begin
          shift   = 1'b0;
          load    = 1'b1;
          dout    = pid_byte;
          clr     = 1'b1;
          state_n = PID;
        end
      end
      PID: begin
        shift = tick;
        if (byte_end) begin
          if (pkt_type > 3'd2) begin
            state_n = EOP;
          end else if (pkt_size == '0) begin
            shift   = 1'b0;
            load    = 1'b1;
            dout    = bus.calculated_crc[7:0];
            state_n = CRC_LO;
          end else begin
            shift   = 1'b0;
            load    = 1'b1;
            pop     = 1'b1;
            dout    = bus.tx_packet_data;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        shift  = tick;
        cshift = tick;
        if (byte_end) begin
          shift = 1'b0;
          load  = 1'b1;
          if (byte_cnt == pkt_size) begin
            dout    = bus.calculated_crc[7:0];
            state_n = CRC_LO;
          end else begin
            pop  = 1'b1;
            dout = bus.tx_packet_data;
          end
        end
      end
      CRC_LO: begin
        shift = tick;
        if (byte_end) begin
          shift   = 1'b0;
          load    = 1'b1;
          dout    = bus.calculated_crc[15:8];
          state_n = CRC_HI;
        end
      end
      CRC_HI: begin
        shift = tick;
        if (byte_end) state_n = EOP;
      end
      EOP:  if (eop_cnt == EOP_LAST) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      pkt_type  <= '0;
      pkt_size  <= '0;
      byte_cnt  <= '0;
      bit_timer <= '0;
      bit_cnt   <= '0;
      eop_cnt   <= '0;
      sync_load <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        bit_timer <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        if (req_valid) begin
          pkt_type  <= bus.tx_packet;
          pkt_size  <= (bus.tx_packet_data_size > MAX_SZ) ? MAX_SZ : bus.tx_packet_data_size;
          sync_load <= 1'b1;
        end
      end else begin
        if (state == SYNC && !bus.stuffing) sync_load <= 1'b0;
        if (shifting && !bus.stuffing) begin
          bit_timer <= tick ? '0 : bit_timer + 1'b1;
          if (tick) bit_cnt <= bit_cnt + 3'd1;
        end
        if (pop) byte_cnt <= byte_cnt + 1'b1;
      end
      eop_cnt <= (state == EOP) ? eop_cnt + 1'b1 : '0;
    end
  end

  assign bus.get_tx_packet_data = pop;
  assign bus.crc_clear          = clr;
  assign bus.crc_shift          = cshift;
  assign bus.pts_load           = load;
  assign bus.pts_shift          = shift;
  assign bus.data_out           = dout;
  assign bus.eop                = (state == EOP);
  assign bus.tx_busy            = (state != IDLE);
  assign bus.tx_done            = (state == DONE);
endmodule

// File: tb/tb_tx_packet_ctrl.sv
// Bench for tx_packet_ctrl: per-cycle comparison of all outputs against a
// timeline model derived from bit-time arithmetic.
module tb_tx_packet_ctrl;
  localparam int MB   = 64;
  localparam int CPB  = 8;
  localparam int SW   = $clog2(MB + 1);
  localparam int MAXC = 8000;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  tx_packet_ctrl_if #(.MAX_BYTES(MB)) bus ();
  tx_packet_ctrl #(.MAX_BYTES(MB), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [7:0]  fifo [0:255];
  logic [15:0] obs  [0:MAXC-1];
  int pops;

  // {busy, done, eop, load, shift, crc_clear, crc_shift, pop, data_out}
  function automatic logic [15:0] obs_now();
    return {bus.tx_busy, bus.tx_done, bus.eop, bus.pts_load, bus.pts_shift,
            bus.crc_clear, bus.crc_shift, bus.get_tx_packet_data, bus.data_out};
  endfunction

  function automatic logic [7:0] pid_of(int typ);
    case (typ)
      1: return 8'hC3;
      2: return 8'h4B;
      3: return 8'hD2;
      4: return 8'h5A;
      5: return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(int k, int typ, int sz, logic [15:0] crc);
    if (k == 0) return 8'h80;
    if (k == 1) return pid_of(typ);
    if (k < 2 + sz) return fifo[k-2];
    if (k == 2 + sz) return crc[7:0];
    return crc[15:8];
  endfunction

  function automatic int n_bytes(int typ, int sz);
    return (typ <= 2) ? sz + 4 : 2;
  endfunction

  function automatic int done_cycle(int typ, int sz, int l);
    return 8 * CPB * n_bytes(typ, sz) + 1 + 2 * CPB + l;
  endfunction

  // Expected outputs at cycle c (cycle 0 presents the request); stuffing
  // during [s, s+l) stalls the whole nominal timeline by l cycles.
  function automatic logic [15:0] exp_vec(int c, int typ, int sz, int s, int l, logic [15:0] crc);
    int nb, n, j, k, eop0, dn;
    logic busy, done, eo, ld, sh, clr, cs, pp;
    logic [7:0] d;
    busy = 0; done = 0; eo = 0; ld = 0; sh = 0; clr = 0; cs = 0; pp = 0; d = 8'h00;
    if (l > 0 && c >= s && c < s + l) return 16'h8000;
    n    = (l > 0 && c >= s + l) ? c - l : c;
    nb   = n_bytes(typ, sz);
    eop0 = 8 * CPB * nb + 1;
    dn   = eop0 + 2 * CPB;
    busy = (n >= 1) && (n <= dn);
    eo   = (n >= eop0) && (n < dn);
    done = (n == dn);
    if (n == 1) begin ld = 1; d = 8'h80; end
    if (n >= CPB && n % CPB == 0 && n / CPB <= 8 * nb) begin
      j  = n / CPB;
      sh = 1;
      cs = (typ <= 2) && ((j - 1) / 8 >= 2) && ((j - 1) / 8 < 2 + sz);
      if (j % 8 == 0 && j / 8 < nb) begin
        k   = j / 8;
        sh  = 0;
        ld  = 1;
        d   = exp_byte(k, typ, sz, crc);
        clr = (k == 1);
        pp  = (k >= 2) && (k < 2 + sz);
      end
    end
    return {busy, done, eo, ld, sh, clr, cs, pp, d};
  endfunction

  task automatic fill_fifo();
    for (int i = 0; i < 256; i++) fifo[i] = 8'($urandom);
  endtask

  task automatic drive_packet(input int typ, input int size, input int s, input int l,
                              input int ncyc, input logic [15:0] crc);
    pops = 0;
    bus.calculated_crc = crc;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.tx_packet = 3'(typ);
        bus.tx_packet_data_size = SW'(size);
      end else if (c < 24) begin
        bus.tx_packet = 3'($urandom);
        bus.tx_packet_data_size = SW'($urandom);
      end else begin
        bus.tx_packet = 3'd0;
      end
      bus.stuffing = (l > 0 && c >= s && c < s + l);
      bus.tx_packet_data = fifo[pops % 256];
      #1;
      obs[c] = obs_now();
      if (bus.get_tx_packet_data) pops++;
    end
    bus.tx_packet = 3'd0;
    bus.stuffing = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    compared++;
    if (obs_now() !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want %h", obs_now(), 16'h0000);
    end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ack_timing();
    int n;
    n = done_cycle(3, 0, 0) + 2;
    drive_packet(3, 0, 0, 0, n, 16'h0000);
    for (int c = 0; c < n; c++) begin
      compared++;
      if (obs[c] !== exp_vec(c, 3, 0, 0, 0, 16'h0000)) begin
        mismatched++;
        $display("FAIL ack cycle %0d: got %h want %h", c, obs[c], exp_vec(c, 3, 0, 0, 0, 16'h0000));
      end
    end
    compared++;
    if (obs[145] !== 16'hC000) begin
      mismatched++;
      $display("FAIL ack_done145: got %h want %h", obs[145], 16'hC000);
    end
  endtask

  task automatic test_data1_fixed();
    int n, np, ncs, ncl;
    fill_fifo();
    fifo[0] = 8'hA5; fifo[1] = 8'h5A;
    n = done_cycle(2, 2, 0) + 2;
    drive_packet(2, 2, 0, 0, n, 16'h1234);
    np = 0; ncs = 0; ncl = 0;
    for (int c = 0; c < n; c++) begin
      compared++;
      if (obs[c] !== exp_vec(c, 2, 2, 0, 0, 16'h1234)) begin
        mismatched++;
        $display("FAIL data1 cycle %0d: got %h want %h", c, obs[c], exp_vec(c, 2, 2, 0, 0, 16'h1234));
      end
      np += int'(obs[c][8]); ncs += int'(obs[c][9]); ncl += int'(obs[c][10]);
    end
    compared++;
    if (np !== 2 || ncs !== 16 || ncl !== 1) begin
      mismatched++;
      $display("FAIL data1_counts: got pops=%0d crc_shift=%0d clear=%0d want 2/16/1", np, ncs, ncl);
    end
  endtask

  task automatic test_zero_len();
    int n;
    logic [15:0] crc;
    crc = 16'($urandom);
    n = done_cycle(1, 0, 0) + 2;
    drive_packet(1, 0, 0, 0, n, crc);
    for (int c = 0; c < n; c++) begin
      compared++;
      if (obs[c] !== exp_vec(c, 1, 0, 0, 0, crc)) begin
        mismatched++;
        $display("FAIL zero_len cycle %0d: got %h want %h", c, obs[c], exp_vec(c, 1, 0, 0, 0, crc));
      end
    end
  endtask

  task automatic test_random();
    int n, typ, sz;
    logic [15:0] crc;
    for (int p = 0; p < 6; p++) begin
      fill_fifo();
      typ = int'($urandom_range(1, 5));
      sz  = int'($urandom_range(0, 10));
      crc = 16'($urandom);
      n = done_cycle(typ, sz, 0) + 2;
      drive_packet(typ, sz, 0, 0, n, crc);
      for (int c = 0; c < n; c++) begin
        compared++;
        if (obs[c] !== exp_vec(c, typ, sz, 0, 0, crc)) begin
          mismatched++;
          $display("FAIL random%0d type %0d size %0d cycle %0d: got %h want %h",
                   p, typ, sz, c, obs[c], exp_vec(c, typ, sz, 0, 0, crc));
        end
      end
    end
  endtask

  task automatic test_stuffing();
    int n, s;
    logic [15:0] crc;
    fill_fifo();
    crc = 16'($urandom);
    s = 8 * CPB * 2 + 20;
    n = done_cycle(2, 4, 8) + 2;
    drive_packet(2, 4, s, 8, n, crc);
    for (int c = 0; c < n; c++) begin
      compared++;
      if (obs[c] !== exp_vec(c, 2, 4, s, 8, crc)) begin
        mismatched++;
        $display("FAIL stuffing cycle %0d: got %h want %h", c, obs[c], exp_vec(c, 2, 4, s, 8, crc));
      end
    end
  endtask

  task automatic test_oversize();
    int n, np;
    logic [15:0] crc;
    fill_fifo();
    crc = 16'($urandom);
    n = done_cycle(1, MB, 0) + 2;
    drive_packet(1, 100, 0, 0, n, crc);
    np = 0;
    for (int c = 0; c < n; c++) begin
      compared++;
      if (obs[c] !== exp_vec(c, 1, MB, 0, 0, crc)) begin
        mismatched++;
        $display("FAIL oversize cycle %0d: got %h want %h", c, obs[c], exp_vec(c, 1, MB, 0, 0, crc));
      end
      np += int'(obs[c][8]);
    end
    compared++;
    if (np !== MB) begin
      mismatched++;
      $display("FAIL oversize_pops: got %0d want %0d", np, MB);
    end
  endtask

  task automatic test_back_to_back();
    int c, dcyc, got;
    bit seen;
    c = 0; dcyc = -1;
    @(posedge clk); #1;
    bus.tx_packet = 3'd4;
    bus.tx_packet_data_size = '0;
    #1;
    while (c < 400 && dcyc < 0) begin
      @(posedge clk); #2;
      c++;
      obs[c] = obs_now();
      if (bus.tx_done) dcyc = c;
    end
    compared++;
    if (dcyc != done_cycle(4, 0, 0)) begin
      mismatched++;
      $display("FAIL b2b_done_cycle: got %0d want %0d", dcyc, done_cycle(4, 0, 0));
    end else begin
      @(posedge clk); #2;
      compared++;
      if (obs_now() !== 16'h0000) begin
        mismatched++;
        $display("FAIL b2b_idle_gap: got %h want %h", obs_now(), 16'h0000);
      end
      @(posedge clk); #2;
      compared++;
      if (obs_now() !== 16'h9080) begin
        mismatched++;
        $display("FAIL b2b_restart: got %h want %h", obs_now(), 16'h9080);
      end
    end
    bus.tx_packet = 3'd0;
    seen = 0; got = 0;
    while (got < 400 && !seen) begin
      @(posedge clk); #2;
      got++;
      if (bus.tx_done) seen = 1;
    end
    @(posedge clk); #2;
    compared++;
    if (!seen || bus.tx_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_second_end: got done_seen=%0d busy=%b want 1/0", seen, bus.tx_busy);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    fill_fifo();
    bus.calculated_crc = 16'($urandom);
    @(posedge clk); #1;
    bus.tx_packet = 3'd1;
    bus.tx_packet_data_size = SW'(8);
    @(posedge clk); #1;
    bus.tx_packet = 3'd0;
    repeat (150) @(posedge clk);
    #3;
    compared++;
    if (bus.tx_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset_pre_busy: got %b want 1", bus.tx_busy);
    end
    n_rst = 1'b0;
    #1;
    compared++;
    if (obs_now() !== 16'h0000) begin
      mismatched++;
      $display("FAIL mid_reset_async: got %h want %h", obs_now(), 16'h0000);
    end
    @(negedge clk); n_rst = 1'b1;
    n = done_cycle(5, 0, 0) + 2;
    drive_packet(5, 0, 0, 0, n, 16'h0000);
    for (int c = 0; c < n; c++) begin
      compared++;
      if (obs[c] !== exp_vec(c, 5, 0, 0, 0, 16'h0000)) begin
        mismatched++;
        $display("FAIL resume cycle %0d: got %h want %h", c, obs[c], exp_vec(c, 5, 0, 0, 0, 16'h0000));
      end
    end
  endtask

  task automatic test_invalid();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.tx_packet = (c % 2 == 0) ? 3'd7 : 3'd6;
      bus.tx_packet_data_size = SW'($urandom);
      #1;
      compared++;
      if (obs_now() !== 16'h0000) begin
        mismatched++;
        $display("FAIL invalid cycle %0d: got %h want %h", c, obs_now(), 16'h0000);
      end
    end
    bus.tx_packet = 3'd0;
  endtask

  initial begin
    bus.tx_packet = 3'd0;
    bus.tx_packet_data = 8'h00;
    bus.tx_packet_data_size = '0;
    bus.stuffing = 1'b0;
    bus.calculated_crc = 16'h0000;
    fill_fifo();
    test_reset();
    test_ack_timing();
    test_data1_fixed();
    test_zero_len();
    test_random();
    test_stuffing();
    test_oversize();
    test_back_to_back();
    test_mid_reset();
    test_invalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
